// File: rtl/control_sequencer.sv
// Multi-cycle instruction control sequencer: walks pc from 0 to LAST_PC, decoding the
// 3-bit opcode latched in FETCH into registered datapath strobes, then halts.
module control_sequencer #(
  parameter logic [7:0] LAST_PC = 8'd5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic       mem_ready,
  output logic [7:0] pc,
  output logic       reg_write,
  output logic       alu_src_imm,
  output logic [1:0] alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       busy,
  output logic       halted,
  output logic [7:0] instr_count
);

  localparam int unsigned PC_W  = 8;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 8;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_ADDI = 3'b100;
  localparam logic [OP_W-1:0] OP_LW   = 3'b110;
  localparam logic [OP_W-1:0] OP_SW   = 3'b101;
  localparam logic [OP_W-1:0] OP_SLL  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [OP_W-1:0]    ir_op_q, ir_op_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               retire;

  logic               reg_write_q, reg_write_d;
  logic               alu_src_imm_q, alu_src_imm_d;
  logic [1:0]         alu_op_q, alu_op_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic               mem_to_reg_q, mem_to_reg_d;
  logic               busy_q, busy_d;
  logic               halted_q, halted_d;
  logic               imm_op_d;

  // Next-state, pc and retire-counter logic.
  always_comb begin
    state_d = state_q;
    ir_op_d = ir_op_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    retire  = 1'b0;

    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        ir_op_d = opcode;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        unique case (ir_op_q)
          OP_ADD, OP_ADDI, OP_SLL: state_d = S_WB;
          OP_LW, OP_SW:            state_d = S_MEM;
          default:                 retire  = 1'b1;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (ir_op_q == OP_LW) state_d = S_WB;
          else                  retire  = 1'b1;
        end
      end
      S_WB:     retire  = 1'b1;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase

    if (retire) begin
      cnt_d = (cnt_q == CNT_W'(255)) ? cnt_q : cnt_q + CNT_W'(1);
      if (pc_q == LAST_PC) begin
        state_d = S_HALT;
      end else begin
        pc_d    = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
    end
  end

  // Moore strobes decoded from the upcoming state so the registered copies line up with it.
  always_comb begin
    imm_op_d      = (ir_op_d == OP_ADDI) || (ir_op_d == OP_LW) ||
                    (ir_op_d == OP_SW)   || (ir_op_d == OP_SLL);
    reg_write_d   = (state_d == S_WB);
    mem_to_reg_d  = (state_d == S_WB)  && (ir_op_d == OP_LW);
    mem_read_d    = (state_d == S_MEM) && (ir_op_d == OP_LW);
    mem_write_d   = (state_d == S_MEM) && (ir_op_d == OP_SW);
    alu_src_imm_d = ((state_d == S_EXEC) || (state_d == S_MEM) || (state_d == S_WB)) && imm_op_d;
    alu_op_d      = (((state_d == S_EXEC) || (state_d == S_WB)) && (ir_op_d == OP_SLL)) ?
                    2'b01 : 2'b00;
    busy_d        = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d      = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ir_op_q       <= '0;
      pc_q          <= '0;
      cnt_q         <= '0;
      reg_write_q   <= 1'b0;
      alu_src_imm_q <= 1'b0;
      alu_op_q      <= 2'b00;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_op_q       <= ir_op_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      reg_write_q   <= reg_write_d;
      alu_src_imm_q <= alu_src_imm_d;
      alu_op_q      <= alu_op_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
    end
  end

  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign reg_write   = reg_write_q;
  assign alu_src_imm = alu_src_imm_q;
  assign alu_op      = alu_op_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_to_reg  = mem_to_reg_q;
  assign busy        = busy_q;
  assign halted      = halted_q;

endmodule
